// File: rtl/cache_debug_scanner.sv
// Cache debug-port scanner: walks an index range over an Avalon-MM debug responder
// and streams status plus four data words per line as 5-word records.
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | writing the line address to debug word 0
// READ  | reading status (sel=0) or data word sel-1
// PUSH  | presenting the captured word on the record stream
// NEXT  | end of line: finish the scan or advance the index
module cache_debug_scanner #(
    parameter int INDEX_BITS   = 12,
    parameter int INDEX_LSB    = 4,
    parameter int SKIP_INVALID = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [INDEX_BITS-1:0] first_index,
    input  logic [INDEX_BITS-1:0] last_index,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_address,
    output logic                  dbg_read,
    output logic                  dbg_write,
    output logic [31:0]           dbg_writedata,
    input  logic                  dbg_waitrequest,
    input  logic [31:0]           dbg_readdata,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic                  out_last,
    input  logic                  out_ready
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_PUSH, S_NEXT} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic [INDEX_BITS-1:0] last_q, last_d;
    logic [2:0]            sel_q, sel_d;
    logic [31:0]           hold_q;
    logic [31:0]           wdata_q;
    logic [2:0]            addr_q;
    logic                  busy_q, done_q, read_q, write_q, valid_q, olast_q, abort_q;
    logic                  abort_pend, rd_acc, wr_acc, skip_line;

    function automatic logic [31:0] line_word(input logic [INDEX_BITS-1:0] idx);
        logic [31:0] w;
        w = '0;
        w[INDEX_BITS-1:0] = idx;
        return w << INDEX_LSB;
    endfunction

    // sel 0 is the status word; sel 1..4 map onto data words at addresses 4..7
    function automatic logic [2:0] word_addr(input logic [2:0] sel);
        return (sel == 3'd0) ? 3'd0 : sel + 3'd3;
    endfunction

    assign rd_acc     = (state_q == S_READ) && !dbg_waitrequest;
    assign wr_acc     = (state_q == S_ADDR) && !dbg_waitrequest;
    assign abort_pend = abort_q | abort;
    assign skip_line  = (SKIP_INVALID != 0) && (sel_q == 3'd0) && (dbg_readdata[3:2] == 2'b00);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        sel_d   = sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = first_index;
                    last_d  = last_index;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (wr_acc) begin
                    sel_d   = 3'd0;
                    state_d = abort_pend ? S_IDLE : S_READ;
                end
            end
            S_READ: begin
                if (rd_acc) begin
                    if (skip_line)       state_d = S_NEXT;
                    else if (abort_pend) state_d = S_IDLE;
                    else                 state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (out_ready) begin
                    if (sel_q == 3'd4) begin
                        state_d = S_NEXT;
                    end else if (abort_pend) begin
                        state_d = S_IDLE;
                    end else begin
                        sel_d   = sel_q + 3'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_NEXT: begin
                if (abort_pend || (idx_q == last_q)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes/data hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
            olast_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            if (rd_acc) hold_q <= dbg_readdata;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q != S_IDLE) && (state_d == S_IDLE);
            write_q <= (state_d == S_ADDR);
            wdata_q <= (state_d == S_ADDR) ? line_word(idx_d) : 32'd0;
            read_q  <= (state_d == S_READ);
            addr_q  <= (state_d == S_READ) ? word_addr(sel_d) : 3'd0;
            valid_q <= (state_d == S_PUSH);
            olast_q <= (state_d == S_PUSH) && (sel_d == 3'd4);
            abort_q <= (state_d == S_IDLE) ? 1'b0 : (abort_q | (abort && busy_q));
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_address   = addr_q;
    assign dbg_read      = read_q;
    assign dbg_write     = write_q;
    assign dbg_writedata = wdata_q;
    assign out_valid     = valid_q;
    assign out_data      = hold_q;
    assign out_last      = olast_q;

endmodule
